// File: rtl/prog_freq_div_pkg.sv
// Shared types and constants for the programmable frequency divider.
package prog_freq_div_pkg;

  localparam int MIN_DIV = 2;
  localparam int PCNT_W  = 16;

  typedef enum logic [1:0] {
    RST  = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

endpackage

// File: rtl/prog_freq_div_div_counter.sv
// Wrapping 0..N-1 counter with registered high/last flags that track the count.
module div_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ratio_cur,
  input  logic [WIDTH-1:0] ratio_nxt,
  output logic [WIDTH-1:0] cnt,
  output logic             high,
  output logic             last
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             high_q, high_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] ratio_sel;

  // Flags are computed for the count being loaded, so they line up with it;
  // at a wrap the incoming ratio already governs count 0.
  always_comb begin
    cnt_d     = cnt_q + WIDTH'(1);
    ratio_sel = ratio_cur;
    if (start) begin
      cnt_d = '0;
    end else if (last_q) begin
      cnt_d     = '0;
      ratio_sel = ratio_nxt;
    end
    high_d = (cnt_d < (ratio_sel >> 1));
    last_d = (cnt_d == (ratio_sel - WIDTH'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      high_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      high_q <= high_d;
      last_q <= last_d;
    end
  end

  assign cnt  = cnt_q;
  assign high = high_q;
  assign last = last_q;

endmodule

// File: rtl/prog_freq_div.sv
// Programmable integer frequency divider with glitch-free ratio reload.
// Optional completed-period counter enabled by PROG_FREQ_DIV_PERIOD_CNT_EN.
module prog_freq_div
  import prog_freq_div_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_busy,
  output logic             div_err,
  output logic             div_out,
  output logic             tick,
  output state_t           dbg_state
`ifdef PROG_FREQ_DIV_PERIOD_CNT_EN
  ,
  output logic [PCNT_W-1:0] period_cnt
`endif
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             err_q, err_d;
  logic             load_ok, load_bad;
  logic [WIDTH-1:0] ratio_nxt;
  logic [WIDTH-1:0] cnt_w;
  logic             high_w, last_w;

  // Loads are ignored while the divider is still coming out of reset.
  assign load_ok  = div_load && (state_q != RST) && (div_val >= WIDTH'(MIN_DIV));
  assign load_bad = div_load && (state_q != RST) && (div_val <  WIDTH'(MIN_DIV));

  // A load in the tick cycle bypasses the pending register.
  assign ratio_nxt = load_ok ? div_val : ((state_q == PEND) ? pend_q : act_q);

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    pend_d  = pend_q;
    err_d   = load_bad;
    case (state_q)
      RST:  state_d = RUN;
      RUN: begin
        if (load_ok && !last_w) begin
          state_d = PEND;
          pend_d  = div_val;
        end
      end
      PEND: begin
        if (last_w)       state_d = RUN;
        else if (load_ok) pend_d  = div_val;
      end
      default: state_d = RST;
    endcase
    if ((state_q != RST) && last_w) act_d = ratio_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST;
      act_q   <= WIDTH'(DEFAULT_DIV);
      pend_q  <= WIDTH'(DEFAULT_DIV);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  div_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .start     (state_q == RST),
    .ratio_cur (act_q),
    .ratio_nxt (ratio_nxt),
    .cnt       (cnt_w),
    .high      (high_w),
    .last      (last_w)
  );

  assign div_out   = high_w;
  assign tick      = last_w;
  assign div_busy  = (state_q == PEND);
  assign div_err   = err_q;
  assign dbg_state = state_q;

`ifdef PROG_FREQ_DIV_PERIOD_CNT_EN
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;

  always_comb begin
    pcnt_d = pcnt_q;
    if ((state_q != RST) && last_w) pcnt_d = pcnt_q + PCNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

  assign period_cnt = pcnt_q;
`endif

  logic unused_cnt;
  assign unused_cnt = ^cnt_w;

endmodule

// File: tb/tb_prog_freq_div.sv
// Directed bench for prog_freq_div: reset, default ratio, loads, rejects, reset abort.
module tb_prog_freq_div;
  import prog_freq_div_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] div_val;
  logic       div_load;
  logic       div_busy, div_err, div_out, tick;
  state_t     dbg_state;
`ifdef PROG_FREQ_DIV_PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] obs, exp_v;

  always #5 clk = ~clk;

  prog_freq_div #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .div_val   (div_val),
    .div_load  (div_load),
    .div_busy  (div_busy),
    .div_err   (div_err),
    .div_out   (div_out),
    .tick      (tick),
    .dbg_state (dbg_state)
`ifdef PROG_FREQ_DIV_PERIOD_CNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // obs/exp_v packing: {div_out, tick, div_busy, div_err}
  task automatic test_reset();
    rst = 1'b1; div_load = 1'b0; div_val = '0;
    repeat (3) step();
    obs = {div_out, tick, div_busy, div_err};
    n_vec++;
    if (obs !== 4'b0000) begin
      n_err++; $display("FAIL reset_outs got %b want 0000", obs);
    end
`ifdef PROG_FREQ_DIV_PERIOD_CNT_EN
    n_vec++;
    if (period_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_pcnt got %0d want 0", period_cnt);
    end
`endif
    rst = 1'b0;
    obs = {div_out, tick, div_busy, div_err};
    n_vec++;
    if (obs !== 4'b0000) begin
      n_err++; $display("FAIL release_cycle got %b want 0000", obs);
    end
    step();
  endtask

  task automatic test_default();
    for (int i = 0; i < 20; i++) begin
      obs   = {div_out, tick, div_busy, div_err};
      exp_v = {(i % 2) == 0, (i % 2) == 1, 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL default[%0d] got %b want %b", i, obs, exp_v);
      end
`ifdef PROG_FREQ_DIV_PERIOD_CNT_EN
      n_vec++;
      if (period_cnt !== 16'(i / 2)) begin
        n_err++; $display("FAIL default_pcnt[%0d] got %0d want %0d", i, period_cnt, i / 2);
      end
`endif
      step();
    end
  endtask

  task automatic test_load5();
    div_load = 1'b1; div_val = 8'd5;
    obs = {div_out, tick, div_busy, div_err};
    n_vec++;
    if (obs !== 4'b1000) begin
      n_err++; $display("FAIL load5_issue got %b want 1000", obs);
    end
    step();
    div_load = 1'b0;
    obs = {div_out, tick, div_busy, div_err};
    n_vec++;
    if (obs !== 4'b0110) begin
      n_err++; $display("FAIL load5_busy got %b want 0110", obs);
    end
    step();
    for (int i = 0; i < 10; i++) begin
      obs   = {div_out, tick, div_busy, div_err};
      exp_v = {(i % 5) < 2, (i % 5) == 4, 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL ratio5[%0d] got %b want %b", i, obs, exp_v);
      end
      step();
    end
  endtask

  task automatic test_reject();
    div_load = 1'b1; div_val = 8'd0;
    step();
    div_val = 8'd1;
    obs = {div_out, tick, div_busy, div_err};
    n_vec++;
    if (obs !== 4'b1001) begin
      n_err++; $display("FAIL reject0 got %b want 1001", obs);
    end
    step();
    div_load = 1'b0;
    obs = {div_out, tick, div_busy, div_err};
    n_vec++;
    if (obs !== 4'b0001) begin
      n_err++; $display("FAIL reject1 got %b want 0001", obs);
    end
    step();
    for (int i = 3; i < 10; i++) begin
      obs   = {div_out, tick, div_busy, div_err};
      exp_v = {(i % 5) < 2, (i % 5) == 4, 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL reject_after[%0d] got %b want %b", i, obs, exp_v);
      end
      step();
    end
  endtask

  task automatic test_last_wins();
    logic [3:0] seq [5];
    seq = '{4'b1000, 4'b1010, 4'b0010, 4'b0010, 4'b0110};
    for (int i = 0; i < 5; i++) begin
      div_load = (i < 2);
      div_val  = (i == 0) ? 8'd7 : 8'd3;
      obs = {div_out, tick, div_busy, div_err};
      n_vec++;
      if (obs !== seq[i]) begin
        n_err++; $display("FAIL lastwins_pend[%0d] got %b want %b", i, obs, seq[i]);
      end
      step();
    end
    div_load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      obs   = {div_out, tick, div_busy, div_err};
      exp_v = {(i % 3) < 1, (i % 3) == 2, 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL ratio3[%0d] got %b want %b", i, obs, exp_v);
      end
      step();
    end
  endtask

  task automatic test_tick_load();
    step();
    step();
    div_load = 1'b1; div_val = 8'd4;
    obs = {div_out, tick, div_busy, div_err};
    n_vec++;
    if (obs !== 4'b0100) begin
      n_err++; $display("FAIL tickload_issue got %b want 0100", obs);
    end
    step();
    div_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      obs   = {div_out, tick, div_busy, div_err};
      exp_v = {(i % 4) < 2, (i % 4) == 3, 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL ratio4[%0d] got %b want %b", i, obs, exp_v);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] seq [4];
    seq = '{4'b1000, 4'b1010, 4'b0010, 4'b0110};
    for (int i = 0; i < 4; i++) begin
      div_load = (i == 0);
      div_val  = 8'd255;
      obs = {div_out, tick, div_busy, div_err};
      n_vec++;
      if (obs !== seq[i]) begin
        n_err++; $display("FAIL r255_pend[%0d] got %b want %b", i, obs, seq[i]);
      end
      step();
    end
    div_load = 1'b0;
    for (int i = 0; i < 50; i++) begin
      obs = {div_out, tick, div_busy, div_err};
      n_vec++;
      if (obs !== 4'b1000) begin
        n_err++; $display("FAIL ratio255[%0d] got %b want 1000", i, obs);
      end
      step();
    end
    rst = 1'b1;
    step();
    obs = {div_out, tick, div_busy, div_err};
    n_vec++;
    if (obs !== 4'b0000) begin
      n_err++; $display("FAIL midreset_outs got %b want 0000", obs);
    end
`ifdef PROG_FREQ_DIV_PERIOD_CNT_EN
    n_vec++;
    if (period_cnt !== 16'd0) begin
      n_err++; $display("FAIL midreset_pcnt got %0d want 0", period_cnt);
    end
`endif
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      obs   = {div_out, tick, div_busy, div_err};
      exp_v = {(i % 2) == 0, (i % 2) == 1, 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL post_reset[%0d] got %b want %b", i, obs, exp_v);
      end
`ifdef PROG_FREQ_DIV_PERIOD_CNT_EN
      n_vec++;
      if (period_cnt !== 16'(i / 2)) begin
        n_err++; $display("FAIL post_reset_pcnt[%0d] got %0d want %0d", i, period_cnt, i / 2);
      end
`endif
      step();
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_load5();
    test_reject();
    test_last_wins();
    test_tick_load();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prog_freq_div.md
# prog_freq_div

Programmable single-clock frequency divider that generates a divided square wave and a one-cycle period strobe for any integer ratio from 2 to 2^WIDTH-1, even or odd. It sits directly downstream of the fixed power-of-two divider, in the same `clk` domain. It extends fixed /2../32 division to arbitrary ratios and lets the ratio be reloaded at run time without producing a glitched period. Outputs are clock-enable-style registered signals in the `clk` domain, not new clock domains.

## Interface
- `WIDTH`, 8: divisor width; maximum ratio is 2^WIDTH-1.
- `DEFAULT_DIV`, 2: ratio active out of reset; must be in 2..2^WIDTH-1.
- Reset is synchronous and active-high: `rst` is sampled only on the rising edge of `clk`.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous reset, active-high.
- `div_val`  in  WIDTH  requested ratio; sampled only when `div_load`=1.
- `div_load`  in  1  one-cycle load request.
- `div_busy`  out  1  a validated ratio is pending and not yet applied.
- `div_err`  out  1  one-cycle pulse: the last load was rejected.
- `div_out`  out  1  divided square wave.
- `tick`  out  1  high in the last cycle of every output period.
- `period_cnt`  out  16  completed-period count; present only with `PROG_FREQ_DIV_PERIOD_CNT_EN`.

## Operation
- Reset values: `div_out`=0, `tick`=0, `div_busy`=0, `div_err`=0, `period_cnt`=0. Counter cleared; active ratio = `DEFAULT_DIV`; pending ratio discarded.
- A reset asserted mid-period aborts that period immediately, with no partial tick.
- FSM states:
  - `RST`: held in reset.
  - `RUN`: dividing, nothing pending.
  - `PEND`: dividing, pending ratio held.
- FSM transitions:
  - `RST`→`RUN` on the first edge that samples `rst`=0.
  - `RUN`→`PEND` on a valid load in a non-tick cycle.
  - `PEND`→`RUN` at the period boundary.
- Period of ratio N: `div_out`=1 for floor(N/2) cycles, then 0 for ceil(N/2) cycles. `tick`=1 only in the final (low) cycle.
- Counter runs 0..N-1 and wraps to 0. The wrap is the period boundary.
- Load validation: `div_val` < 2 is rejected. `div_err` pulses for 1 cycle, and the active and pending ratios are unchanged.
- Valid load in a non-tick cycle: value goes to the pending register, and `div_busy`=1 from the next cycle. It is applied at the next boundary.
- Valid load while already pending: the new value overwrites the pending one (last wins).
- Valid load coincident with `tick`=1: applied at that same boundary. `div_busy` does not assert.
- Reloading the active ratio is legal. The period restarts cleanly at the boundary, with no phase change.
- All arithmetic is unsigned WIDTH-bit. The counter never exceeds N-1, so there is no overflow at N=2^WIDTH-1.

## Timing
- All outputs are registered with no combinational input→output paths.
- Start-up: the first edge sampling `rst`=0 begins period 0. `div_out`=1 in the following cycle.
- Load→`div_busy`: 1 cycle.
- Load→`div_err`: 1 cycle; the pulse is 1 cycle wide.
- Boundary: `div_busy` falls in the first cycle of the new period; the new ratio governs that period.
- `tick` and the `div_out` 0→1 transition are separated by exactly one edge.
- `period_cnt` increments in the cycle after `tick` and wraps at 2^16-1 → 0.

## Configuration
- `PROG_FREQ_DIV_PERIOD_CNT_EN` defined: the `period_cnt` port and its 16-bit counter exist.
- `PROG_FREQ_DIV_PERIOD_CNT_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- `prog_freq_div_pkg` holds:
  - the FSM state enum (`RST`, `RUN`, `PEND`);
  - `MIN_DIV`=2;
  - the `period_cnt` width constant 16.
- Sub-module `div_counter` provides the wrapping 0..N-1 counter with `last` (count = N-1) and `high` (count < floor(N/2)) flags.
- The top level owns load validation, the pending register, the FSM and the output registers.

## Test plan
- Reset, then 20 cycles, `DEFAULT_DIV`=2 → `div_out` 1,0,1,0…; `tick` on every 0 cycle; `div_busy`=`div_err`=0.
- Load 5 mid-period → `div_busy`=1 until the boundary; then `div_out` 1,1,0,0,0 repeating; `tick` every 5th cycle.
- Load 0, then 1 → `div_err` pulses once per load; period unchanged; `div_busy` stays 0.
- Load 7 then 3 in consecutive cycles → ratio 3 applied at the boundary (1 high, 2 low); 7 is never seen.
- Load 4 coincident with `tick` → next period is 2 high / 2 low; `div_busy` never 1.
- Reset asserted mid-period at ratio 255 → all outputs 0 next cycle. On release, ratio 2; `period_cnt` restarts at 0 (macro defined).
